image_read_arbiter: RTL

//  Shares the single image-buffer read port (readEnable/readAddr/readData)

---
 rtl/image_read_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/image_read_arbiter.sv
// Round-robin burst arbiter sharing one image-buffer read port between NREQ requesters.
// Bursts are issued as back-to-back single-cycle reads; returned data is steered by gnt.
module image_read_arbiter #(
    parameter int NREQ   = 2,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 12,
    parameter int LEN_W  = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*ADDR_W-1:0]   start_addr,
    input  logic [NREQ*LEN_W-1:0]    burst_len,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          rd_valid,
    output logic [DATA_W-1:0]        rd_data,
    output logic [NREQ-1:0]          done,
    output logic                     mem_ren,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic [DATA_W-1:0]        mem_rdata
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

    state_t            state;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  owner;
    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0]  rem;
    logic              ren_d;
    logic              zero_hold;

    logic              pick_valid;
    logic [IDX_W-1:0]  pick;
    logic [IDX_W-1:0]  cand;
    logic [ADDR_W-1:0] pick_addr;
    logic [LEN_W-1:0]  pick_len;

    // First requesting index at or above rr_ptr, wrapping around.
    always_comb begin
        pick_valid = 1'b0;
        pick       = '0;
        cand       = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IDX_W'((int'(rr_ptr) + i) % NREQ);
            if (!pick_valid && req[cand]) begin
                pick_valid = 1'b1;
                pick       = cand;
            end
        end
    end

    assign pick_addr = start_addr[pick*ADDR_W +: ADDR_W];
    assign pick_len  = burst_len[pick*LEN_W +: LEN_W];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            gnt       <= '0;
            done      <= '0;
            mem_ren   <= 1'b0;
            mem_addr  <= '0;
            rr_ptr    <= '0;
            owner     <= '0;
            cur_addr  <= '0;
            rem       <= '0;
            ren_d     <= 1'b0;
            zero_hold <= 1'b0;
        end else begin
            ren_d <= mem_ren;
            case (state)
                IDLE: begin
                    done <= '0;
                    if (pick_valid) begin
                        owner <= pick;
                        gnt   <= ONE << pick;
                        rem   <= pick_len;
                        if (pick_len == '0) begin
                            // zero-length burst: hold one extra cycle so done lands a cycle later
                            state     <= DRAIN;
                            zero_hold <= 1'b1;
                            mem_ren   <= 1'b0;
                        end else begin
                            state    <= BURST;
                            mem_ren  <= 1'b1;
                            mem_addr <= pick_addr;
                            cur_addr <= pick_addr + 1'b1;
                        end
                    end
                end
                BURST: begin
                    if (rem == LEN_W'(1)) begin
                        state   <= DRAIN;
                        mem_ren <= 1'b0;
                        done    <= ONE << owner;
                    end else begin
                        mem_addr <= cur_addr;
                        cur_addr <= cur_addr + 1'b1;
                        rem      <= rem - 1'b1;
                    end
                end
                DRAIN: begin
                    if (zero_hold) begin
                        zero_hold <= 1'b0;
                        done      <= ONE << owner;
                    end else begin
                        done   <= '0;
                        gnt    <= '0;
                        rr_ptr <= (owner == IDX_W'(NREQ - 1)) ? '0 : owner + 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rd_valid = {NREQ{ren_d}} & gnt;
    assign rd_data  = mem_rdata;

endmodule
